// File: rtl/exc_ctrl_if.sv
// Memory-stage exception flags, CP0 register snapshot and the controller's CP0/pipeline outputs.
// master = pipeline/CP0 side, slave = exc_ctrl.
interface exc_ctrl_if;
    logic        exc_valid;
    logic [31:0] pc;
    logic        in_bd;
    logic [31:0] bad_addr;
    logic        exc_adel_if;
    logic        exc_ri;
    logic        exc_ov;
    logic        exc_sys;
    logic        exc_bp;
    logic        exc_adel_ld;
    logic        exc_ades_st;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_badvaddr;
    logic        expwrite;
    logic [31:0] out_epc;
    logic [31:0] out_badvaddr;
    logic [31:0] out_status;
    logic [31:0] out_cause;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output exc_valid, pc, in_bd, bad_addr,
        output exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades_st, eret,
        output hw_int, cp0_status, cp0_cause, cp0_epc, cp0_badvaddr,
        input  expwrite, out_epc, out_badvaddr, out_status, out_cause,
        input  flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  exc_valid, pc, in_bd, bad_addr,
        input  exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades_st, eret,
        input  hw_int, cp0_status, cp0_cause, cp0_epc, cp0_badvaddr,
        output expwrite, out_epc, out_badvaddr, out_status, out_cause,
        output flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: prioritises one event, commits CP0, flushes, then redirects PC.
// Latency: event -> redirect in 2+FLUSH_CYCLES cycles; busy holds off new events (inputs ignored).
// Optional timer interrupt on IP[7] when EXC_TIMER_INT_EN is defined.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
`ifdef EXC_TIMER_INT_EN
    ,
    parameter logic [31:0] TIMER_PERIOD = 32'd100000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] flush_cnt;
    logic [5:0]    hw_meta, hw_sync;
    logic [7:0]    ip;
    logic          int_take, flag_hit, eret_take, start;
    logic [4:0]    exc_code;
    logic [31:0]   exc_badv;
    logic [31:0]   epc_q, cause_q, status_q, badv_q, target_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hw_meta <= '0;
            hw_sync <= '0;
        end else begin
            hw_meta <= bus.hw_int;
            hw_sync <= hw_meta;
        end
    end

`ifdef EXC_TIMER_INT_EN
    logic [31:0] tmr_cnt;
    logic        tmr_pend;
    logic        tmr_clr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmr_cnt  <= '0;
            tmr_pend <= 1'b0;
        end else begin
            if (state == COMMIT && tmr_clr_q)
                tmr_pend <= 1'b0;
            // A wrap in the same cycle as the clear re-arms the pending bit
            if (tmr_cnt == TIMER_PERIOD - 32'd1) begin
                tmr_cnt  <= '0;
                tmr_pend <= 1'b1;
            end else begin
                tmr_cnt <= tmr_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            tmr_clr_q <= 1'b0;
        else if (state == IDLE && start)
            tmr_clr_q <= int_take & ip[7];
    end

    assign ip = {hw_sync[5] | tmr_pend, hw_sync[4:0], bus.cp0_cause[9:8]};
`else
    assign ip = {hw_sync, bus.cp0_cause[9:8]};
`endif

    assign int_take = bus.exc_valid & bus.cp0_status[0] & ~bus.cp0_status[1]
                    & (|(ip & bus.cp0_status[15:8]));
    assign flag_hit = bus.exc_valid & (bus.exc_adel_if | bus.exc_ri | bus.exc_ov | bus.exc_sys
                    | bus.exc_bp | bus.exc_adel_ld | bus.exc_ades_st);
    assign eret_take = bus.exc_valid & bus.eret & ~int_take & ~flag_hit;
    assign start = int_take | flag_hit | eret_take;

    always_comb begin
        exc_code = 5'd0;
        exc_badv = bus.cp0_badvaddr;
        if (int_take) begin
            exc_code = 5'd0;
        end else if (bus.exc_adel_if) begin
            exc_code = 5'd4;
            exc_badv = bus.pc;
        end else if (bus.exc_ri) begin
            exc_code = 5'd10;
        end else if (bus.exc_ov) begin
            exc_code = 5'd12;
        end else if (bus.exc_sys) begin
            exc_code = 5'd8;
        end else if (bus.exc_bp) begin
            exc_code = 5'd9;
        end else if (bus.exc_adel_ld) begin
            exc_code = 5'd4;
            exc_badv = bus.bad_addr;
        end else if (bus.exc_ades_st) begin
            exc_code = 5'd5;
            exc_badv = bus.bad_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            epc_q    <= '0;
            cause_q  <= '0;
            status_q <= '0;
            badv_q   <= '0;
            target_q <= '0;
        end else if (state == IDLE && start) begin
            if (eret_take) begin
                epc_q    <= bus.cp0_epc;
                cause_q  <= bus.cp0_cause;
                status_q <= {bus.cp0_status[31:2], 1'b0, bus.cp0_status[0]};
                badv_q   <= bus.cp0_badvaddr;
                target_q <= bus.cp0_epc;
            end else begin
                epc_q    <= bus.in_bd ? bus.pc - 32'd4 : bus.pc;
                cause_q  <= {bus.in_bd, bus.cp0_cause[30:16], ip, 1'b0, exc_code, 2'b00};
                status_q <= {bus.cp0_status[31:2], 1'b1, bus.cp0_status[0]};
                badv_q   <= exc_badv;
                target_q <= EXC_VECTOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH)
                flush_cnt <= flush_cnt + 1'b1;
            else
                flush_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = COMMIT;
            COMMIT:   state_nxt = FLUSH;
            FLUSH:    if (flush_cnt == CW'(FLUSH_CYCLES - 1)) state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign bus.expwrite       = (state == COMMIT);
    assign bus.flush          = (state == COMMIT) || (state == FLUSH);
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = target_q;
    assign bus.busy           = (state != IDLE);
    assign bus.out_epc        = epc_q;
    assign bus.out_cause      = cause_q;
    assign bus.out_status     = status_q;
    assign bus.out_badvaddr   = badv_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: reset, exception/interrupt/ERET sequences, priority and ignore cases.
module tb_exc_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    exc_ctrl_if bus();

    exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_flags();
        bus.exc_valid   = 1'b0;
        bus.in_bd       = 1'b0;
        bus.exc_adel_if = 1'b0;
        bus.exc_ri      = 1'b0;
        bus.exc_ov      = 1'b0;
        bus.exc_sys     = 1'b0;
        bus.exc_bp      = 1'b0;
        bus.exc_adel_ld = 1'b0;
        bus.exc_ades_st = 1'b0;
        bus.eret        = 1'b0;
    endtask

    // Called #1 after the edge that entered COMMIT; walks COMMIT, FLUSH x2, REDIRECT, back to IDLE.
    task automatic seq(input string tag, input logic [31:0] e_epc, input logic [31:0] e_cause,
                       input logic [31:0] e_status, input logic [31:0] e_badv, input logic [31:0] e_tgt);
        chk({tag, ".expwrite"}, 32'(bus.expwrite), 32'd1);
        chk({tag, ".flush_c"}, 32'(bus.flush), 32'd1);
        chk({tag, ".epc"}, bus.out_epc, e_epc);
        chk({tag, ".cause"}, bus.out_cause, e_cause);
        chk({tag, ".status"}, bus.out_status, e_status);
        chk({tag, ".badv"}, bus.out_badvaddr, e_badv);
        tick();
        chk({tag, ".f1"}, {30'd0, bus.flush, bus.expwrite}, 32'd2);
        tick();
        chk({tag, ".f2"}, {30'd0, bus.flush, bus.redirect_valid}, 32'd2);
        tick();
        chk({tag, ".redir"}, {29'd0, bus.redirect_valid, bus.flush, bus.busy}, 32'd5);
        chk({tag, ".rpc"}, bus.redirect_pc, e_tgt);
        tick();
        chk({tag, ".idle"}, {30'd0, bus.busy, bus.redirect_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        clr_flags();
        bus.pc = '0; bus.bad_addr = '0; bus.hw_int = '0;
        bus.cp0_status = '0; bus.cp0_cause = '0; bus.cp0_epc = '0; bus.cp0_badvaddr = '0;
        tick(); tick();
        chk("rst.ctl", {28'd0, bus.expwrite, bus.flush, bus.redirect_valid, bus.busy}, 32'd0);
        chk("rst.out", bus.out_epc | bus.out_cause | bus.out_status | bus.out_badvaddr, 32'd0);
        reset = 1'b1;
        tick();

        // Ov beats Sys and Bp
        bus.exc_valid = 1'b1; bus.exc_ov = 1'b1; bus.exc_sys = 1'b1; bus.exc_bp = 1'b1;
        bus.pc = 32'h80001000; bus.cp0_status = 32'h00400001; bus.cp0_badvaddr = 32'h12345678;
        tick(); clr_flags();
        seq("ov", 32'h80001000, 32'h00000030, 32'h00400003, 32'h12345678, 32'hBFC00380);

        // AdES in delay slot
        bus.exc_valid = 1'b1; bus.exc_ades_st = 1'b1; bus.in_bd = 1'b1;
        bus.pc = 32'h80002004; bus.bad_addr = 32'h00000003; bus.cp0_status = 32'h0;
        tick(); clr_flags();
        seq("ades", 32'h80002000, 32'h80000014, 32'h00000002, 32'h00000003, 32'hBFC00380);

        // AdEL-fetch beats RI; EPC wraps below zero
        bus.exc_valid = 1'b1; bus.exc_adel_if = 1'b1; bus.exc_ri = 1'b1; bus.in_bd = 1'b1;
        bus.pc = 32'h00000000; bus.cp0_badvaddr = 32'h00000055;
        tick(); clr_flags();
        seq("adelif", 32'hFFFFFFFC, 32'h80000010, 32'h00000002, 32'h00000000, 32'hBFC00380);

        // Interrupt beats Sys
        bus.hw_int = 6'b000100; bus.cp0_status = 32'h00001001;
        bus.cp0_cause = 32'h40010000; bus.cp0_badvaddr = 32'h11111111;
        tick(); tick(); tick();
        bus.exc_valid = 1'b1; bus.exc_sys = 1'b1; bus.pc = 32'h80005000;
        tick(); clr_flags(); bus.hw_int = '0;
        seq("int", 32'h80005000, 32'h40011000, 32'h00001003, 32'h11111111, 32'hBFC00380);
        tick(); tick();

        // ERET
        bus.cp0_status = 32'h00400003; bus.cp0_cause = 32'h00001234;
        bus.cp0_epc = 32'h80003000; bus.cp0_badvaddr = 32'hDEADBEEF;
        bus.exc_valid = 1'b1; bus.eret = 1'b1;
        tick(); clr_flags();
        seq("eret", 32'h80003000, 32'h00001234, 32'h00400001, 32'hDEADBEEF, 32'h80003000);

        // ERET loses to RI
        bus.exc_valid = 1'b1; bus.eret = 1'b1; bus.exc_ri = 1'b1; bus.pc = 32'h80004000;
        bus.cp0_cause = 32'h0;
        tick(); clr_flags();
        seq("eretri", 32'h80004000, 32'h00000028, 32'h00400003, 32'hDEADBEEF, 32'hBFC00380);

        // Interrupt masked by EXL, and flags without exc_valid
        bus.cp0_status = 32'h0000FF03; bus.hw_int = 6'h3F; bus.exc_valid = 1'b1;
        tick(); tick(); tick(); tick();
        chk("exl.mask", {30'd0, bus.expwrite, bus.busy}, 32'd0);
        bus.hw_int = '0; bus.exc_valid = 1'b0; bus.exc_ov = 1'b1;
        tick(); tick();
        chk("novalid", {30'd0, bus.expwrite, bus.busy}, 32'd0);
        clr_flags(); bus.cp0_status = 32'h0;
        tick(); tick();

        // New flags while busy are ignored
        bus.exc_valid = 1'b1; bus.exc_sys = 1'b1; bus.pc = 32'h80006000; bus.cp0_badvaddr = 32'h0;
        tick();
        bus.exc_sys = 1'b0; bus.exc_ov = 1'b1;
        seq("busy", 32'h80006000, 32'h00000020, 32'h00000002, 32'h00000000, 32'hBFC00380);
        clr_flags();
        tick();
        chk("busy.after", {30'd0, bus.expwrite, bus.busy}, 32'd0);

        // Reset mid-FLUSH
        bus.exc_valid = 1'b1; bus.exc_bp = 1'b1; bus.pc = 32'h80007000;
        tick(); clr_flags();
        tick();
        chk("mid.flush", 32'(bus.flush), 32'd1);
        reset = 1'b0;
        tick(); tick();
        chk("mid.ctl", {28'd0, bus.expwrite, bus.flush, bus.redirect_valid, bus.busy}, 32'd0);
        chk("mid.out", bus.out_epc | bus.out_cause | bus.out_status | bus.redirect_pc, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid.idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
